// File: rtl/regfile_if.sv
// Bus bundle for regfile_param: write port, two read ports, clear request and status.
interface regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              Clear;
  logic              Wren;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic [ADDR_W-1:0] RdAddrA;
  logic [ADDR_W-1:0] RdAddrB;
  logic [DATA_W-1:0] RdDataA;
  logic [DATA_W-1:0] RdDataB;
  logic              Busy;
  logic              WrDrop;

  modport master (
    output Clear, Wren, WrAddr, WrData, RdAddrA, RdAddrB,
    input  RdDataA, RdDataB, Busy, WrDrop
  );

  modport slave (
    input  Clear, Wren, WrAddr, WrData, RdAddrA, RdAddrB,
    output RdDataA, RdDataB, Busy, WrDrop
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 1W/2R register file with optional registered reads, write bypass,
// hardwired-zero R0 and a one-register-per-cycle clear sweep after Reset or Clear.
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int REG_READ = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0
) (
  input  logic      Clk,
  input  logic      Reset,
  regfile_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {READY = 1'b0, CLEARING = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              busy;
  logic              r0_hit;
  logic              wr_ok;
  logic              sweep_we;
  logic              wr_drop, wr_drop_nxt;
  logic [DATA_W-1:0] val_a, val_b;

  // Read-side value: R0 pinning beats the bypass, which beats stored contents.
  function automatic logic [DATA_W-1:0] read_val(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              wr_hit,
    input logic [DATA_W-1:0] wdata
  );
    if (ZERO_R0 != 0 && a == '0) return '0;
    if (BYPASS != 0 && wr_hit)   return wdata;
    return stored;
  endfunction

  assign busy   = (state == CLEARING);
  assign r0_hit = (ZERO_R0 != 0) && (bus.WrAddr == '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= CLEARING;
      clr_addr <= '0;
      wr_drop  <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      wr_drop  <= wr_drop_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    sweep_we     = 1'b0;
    wr_ok        = 1'b0;
    wr_drop_nxt  = 1'b0;
    case (state)
      READY: begin
        // A write coinciding with Clear still lands; the sweep then zeroes it.
        wr_ok       = bus.Wren && !r0_hit && !Reset;
        wr_drop_nxt = bus.Wren && r0_hit;
        if (bus.Clear) begin
          state_nxt    = CLEARING;
          clr_addr_nxt = '0;
        end
      end
      CLEARING: begin
        sweep_we     = 1'b1;
        wr_drop_nxt  = bus.Wren;
        clr_addr_nxt = clr_addr + ADDR_W'(1);
        if (&clr_addr) state_nxt = READY;
      end
      default: state_nxt = READY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (sweep_we)   mem[clr_addr]   <= '0;
    else if (wr_ok) mem[bus.WrAddr] <= bus.WrData;
  end

  assign val_a = read_val(bus.RdAddrA, mem[bus.RdAddrA],
                          wr_ok && (bus.WrAddr == bus.RdAddrA), bus.WrData);
  assign val_b = read_val(bus.RdAddrB, mem[bus.RdAddrB],
                          wr_ok && (bus.WrAddr == bus.RdAddrB), bus.WrData);

  generate
    if (REG_READ != 0) begin : g_reg
      logic [DATA_W-1:0] rd_a_p1, rd_b_p1;
      // Stage p0 -> p1: registered read data, held at zero through Reset and the sweep.
      always_ff @(posedge Clk) begin
        if (Reset || busy) begin
          rd_a_p1 <= '0;
          rd_b_p1 <= '0;
        end else begin
          rd_a_p1 <= val_a;
          rd_b_p1 <= val_b;
        end
      end
      assign bus.RdDataA = rd_a_p1;
      assign bus.RdDataB = rd_b_p1;
    end else begin : g_comb
      assign bus.RdDataA = busy ? '0 : val_a;
      assign bus.RdDataB = busy ? '0 : val_b;
    end
  endgenerate

  assign bus.Busy   = busy;
  assign bus.WrDrop = wr_drop;
endmodule

// File: tb/tb_regfile_param.sv
// Drives three regfile_param configurations in lock-step and compares each against
// an array-based model of the architectural register state.
module tb_regfile_param;
  logic Clk;
  logic Reset;

  regfile_if #(.DATA_W(16), .ADDR_W(4)) if0 ();
  regfile_if #(.DATA_W(16), .ADDR_W(4)) if1 ();
  regfile_if #(.DATA_W(32), .ADDR_W(5)) if2 ();

  regfile_param #(.DATA_W(16), .ADDR_W(4), .REG_READ(1), .BYPASS(1), .ZERO_R0(0))
    u0 (.Clk(Clk), .Reset(Reset), .bus(if0.slave));
  regfile_param #(.DATA_W(16), .ADDR_W(4), .REG_READ(1), .BYPASS(0), .ZERO_R0(1))
    u1 (.Clk(Clk), .Reset(Reset), .bus(if1.slave));
  regfile_param #(.DATA_W(32), .ADDR_W(5), .REG_READ(0), .BYPASS(1), .ZERO_R0(0))
    u2 (.Clk(Clk), .Reset(Reset), .bus(if2.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit seen_rst = 0;

  logic [31:0] mem_m [3][32];
  int          left_m [3];
  logic [31:0] exp_a [3];
  logic [31:0] exp_b [3];
  logic        exp_drop [3];

  function automatic int  aw(int d);    return (d == 2) ? 5 : 4;  endfunction
  function automatic int  dw(int d);    return (d == 2) ? 32 : 16; endfunction
  function automatic int  depth(int d); return 1 << aw(d);        endfunction
  function automatic bit  byp(int d);   return d != 1;            endfunction
  function automatic bit  zr(int d);    return d == 1;            endfunction
  function automatic logic [31:0] am(int d); return 32'(depth(d) - 1); endfunction
  function automatic logic [31:0] dm(int d);
    return (dw(d) == 32) ? 32'hFFFF_FFFF : 32'hFFFF;
  endfunction

  function automatic bit wok_f(int d, bit rst, bit wen, logic [31:0] wa);
    return wen && (left_m[d] == 0) && !rst && !(zr(d) && wa == 0);
  endfunction

  function automatic logic [31:0] mval(int d, logic [31:0] a, bit rst, bit wen,
                                       logic [31:0] wa, logic [31:0] wd);
    if (zr(d) && a == 0) return 32'h0;
    if (byp(d) && wok_f(d, rst, wen, wa) && wa == a) return wd;
    return mem_m[d][a];
  endfunction

  function automatic logic [31:0] obs_rd(int d, bit sel_b);
    case (d)
      0:       return sel_b ? 32'(if0.RdDataB) : 32'(if0.RdDataA);
      1:       return sel_b ? 32'(if1.RdDataB) : 32'(if1.RdDataA);
      default: return sel_b ? if2.RdDataB : if2.RdDataA;
    endcase
  endfunction

  function automatic logic obs_busy(int d);
    case (d)
      0:       return if0.Busy;
      1:       return if1.Busy;
      default: return if2.Busy;
    endcase
  endfunction

  function automatic logic obs_drop(int d);
    case (d)
      0:       return if0.WrDrop;
      1:       return if1.WrDrop;
      default: return if2.WrDrop;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_mem(int d);
    for (int i = 0; i < 32; i++) mem_m[d][i] = 32'h0;
  endtask

  task automatic drive(bit rst, bit clr, bit wen, logic [31:0] wa, logic [31:0] wd,
                       logic [31:0] ra, logic [31:0] rb);
    Reset = rst;
    if0.Clear = clr; if0.Wren = wen; if0.WrAddr = wa[3:0]; if0.WrData = wd[15:0];
    if0.RdAddrA = ra[3:0]; if0.RdAddrB = rb[3:0];
    if1.Clear = clr; if1.Wren = wen; if1.WrAddr = wa[3:0]; if1.WrData = wd[15:0];
    if1.RdAddrA = ra[3:0]; if1.RdAddrB = rb[3:0];
    if2.Clear = clr; if2.Wren = wen; if2.WrAddr = wa[4:0]; if2.WrData = wd;
    if2.RdAddrA = ra[4:0]; if2.RdAddrB = rb[4:0];
  endtask

  // One clock: drive, check combinational reads, advance the model, check registered outputs.
  task automatic step(bit rst, bit clr, bit wen, logic [31:0] wa, logic [31:0] wd,
                      logic [31:0] ra, logic [31:0] rb);
    logic [31:0] a, b, w, dd;
    bit bz, wk;
    @(negedge Clk);
    drive(rst, clr, wen, wa, wd, ra, rb);
    #1;
    if (seen_rst) begin
      a = ra & am(2); b = rb & am(2); w = wa & am(2); dd = wd & dm(2);
      chk("u2.RdDataA", obs_rd(2, 0), (left_m[2] > 0) ? 32'h0 : mval(2, a, rst, wen, w, dd));
      chk("u2.RdDataB", obs_rd(2, 1), (left_m[2] > 0) ? 32'h0 : mval(2, b, rst, wen, w, dd));
    end
    @(posedge Clk);
    for (int d = 0; d < 3; d++) begin
      a = ra & am(d); b = rb & am(d); w = wa & am(d); dd = wd & dm(d);
      bz = left_m[d] > 0;
      wk = wok_f(d, rst, wen, w);
      exp_a[d]    = (rst || bz) ? 32'h0 : mval(d, a, rst, wen, w, dd);
      exp_b[d]    = (rst || bz) ? 32'h0 : mval(d, b, rst, wen, w, dd);
      exp_drop[d] = !rst && wen && (bz || (zr(d) && w == 0));
      if (wk) mem_m[d][w] = dd;
      if (rst) begin
        left_m[d] = depth(d); clr_mem(d);
      end else if (bz) begin
        left_m[d]--;
      end else if (clr) begin
        left_m[d] = depth(d); clr_mem(d);
      end
    end
    if (rst) seen_rst = 1;
    #1;
    if (seen_rst) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("u%0d.Busy", d),   32'(obs_busy(d)), 32'(left_m[d] > 0));
        chk($sformatf("u%0d.WrDrop", d), 32'(obs_drop(d)), 32'(exp_drop[d]));
        if (d < 2) begin
          chk($sformatf("u%0d.RdDataA", d), obs_rd(d, 0), exp_a[d]);
          chk($sformatf("u%0d.RdDataB", d), obs_rd(d, 1), exp_b[d]);
        end
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      left_m[d] = 0; exp_drop[d] = 0; exp_a[d] = 0; exp_b[d] = 0; clr_mem(d);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Reset sweep, then every register reads zero on both ports.
    step(1, 0, 0, 0, 0, 0, 0);
    idle(34);
    for (int k = 0; k < 32; k++) step(0, 0, 0, 0, 0, k, k);
    idle(1);

    // Fill with k*0x1111 pattern (descending so 16-deep copies keep k<16 values).
    for (int k = 31; k >= 0; k--) step(0, 0, 1, k, 32'(k) * 32'h1111_1111, 0, 0);
    for (int k = 0; k < 32; k++) begin
      step(0, 0, 0, 0, 0, k, 31 - k);
      if (k == 7) begin
        chk("u0.r7 direct", obs_rd(0, 0), 32'h7777);
        chk("u0.r8 direct", obs_rd(0, 1), 32'h8888);
      end
    end

    // Same-cycle write/read of r5.
    step(0, 0, 1, 5, 32'hDEAD_BEEF, 5, 5);
    chk("u0.bypass r5", obs_rd(0, 0), 32'hBEEF);
    chk("u1.nobypass r5", obs_rd(1, 0), 32'h5555);
    step(0, 0, 0, 0, 0, 5, 5);
    chk("u1.r5 after write", obs_rd(1, 0), 32'hBEEF);

    // Clear mid-traffic, write during the sweep gets dropped.
    for (int i = 0; i < 6; i++) step(0, 0, 1, $urandom, $urandom, $urandom, $urandom);
    step(0, 1, 1, 3, 32'h1234, 3, 3);
    step(0, 0, 1, 3, 32'h1234, 3, 3);
    chk("u0.WrDrop busy", 32'(obs_drop(0)), 32'h1);
    idle(34);
    step(0, 0, 0, 0, 0, 3, 3);
    chk("u0.r3 cleared", obs_rd(0, 0), 32'h0);

    // Hardwired R0 on u1 only.
    step(0, 0, 1, 0, 32'hFFFF, 0, 1);
    chk("u1.WrDrop r0", 32'(obs_drop(1)), 32'h1);
    chk("u0.WrDrop r0", 32'(obs_drop(0)), 32'h0);
    step(0, 0, 1, 1, 32'hFFFF, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("u1.r0 zero", obs_rd(1, 0), 32'h0);
    chk("u1.r1 write", obs_rd(1, 1), 32'hFFFF);
    chk("u0.r0 write", obs_rd(0, 0), 32'hFFFF);

    // Reset at sweep cycle 8 restarts the full sweep.
    step(1, 0, 0, 0, 0, 0, 0);
    idle(8);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(15);
    chk("u0.Busy restart held", 32'(obs_busy(0)), 32'h1);
    idle(1);
    chk("u0.Busy restart done", 32'(obs_busy(0)), 32'h0);
    idle(17);

    // Random traffic with occasional Clear.
    for (int i = 0; i < 400; i++)
      step(0, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
           $urandom, $urandom, $urandom, $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end
endmodule
